// File: rtl/cpu4_mc_ctrl_pkg.sv
// Shared encodings for the cpu4 multi-cycle control unit: opcodes, functs,
// ALU codes, FSM state encoding and the bundled datapath control word.
package cpu4_mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_e;

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/cpu4_mc_ctrl_aludec.sv
// ALU decoder: turns the FSM's aluop class plus funct into the 3-bit ALU code
// and flags functs the datapath does not implement.
module cpu4_aludec
  import cpu4_mc_ctrl_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       bad_funct_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    bad_funct_o  = 1'b0;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          default: bad_funct_o  = 1'b1;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu4_mc_ctrl.sv
// cpu4 multi-cycle control FSM. Memory handshake: mem_req holds with a stable
// address select until the cycle mem_ready=1 completes it; mem_ready is ignored otherwise.
module cpu4_mc_ctrl
  import cpu4_mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  ctrl_t      ctrl, ctrl_o;
  aluop_e     aluop;
  logic [2:0] alu_code;
  logic       bad_funct;

  cpu4_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alu_code),
    .bad_funct_o  (bad_funct)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = bad_funct ? S_FETCH : S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore decode, except irwrite/pcen in FETCH (mem_ready) and pcen in BRANCH (zero).
  always_comb begin
    ctrl  = '0;
    aluop = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.irwrite = mem_ready;
        ctrl.pcen    = mem_ready;
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.illegal = !op_supported(op);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
      end
      S_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        aluop        = ALUOP_FUNCT;
        ctrl.illegal = bad_funct;
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.pcsrc   = 2'b01;
        ctrl.pcen    = zero;
        aluop        = ALUOP_SUB;
      end
      S_ADDIWB: ctrl.regwrite = 1'b1;
      S_JUMP: begin
        ctrl.pcsrc = 2'b10;
        ctrl.pcen  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset gates every strobe and select combinationally, so nothing fires while it is held.
  assign ctrl_o     = reset ? '0 : ctrl;
  assign alucontrol = reset ? ALU_ADD : alu_code;

  assign mem_req  = ctrl_o.mem_req;
  assign memwrite = ctrl_o.memwrite;
  assign irwrite  = ctrl_o.irwrite;
  assign pcen     = ctrl_o.pcen;
  assign regwrite = ctrl_o.regwrite;
  assign iord     = ctrl_o.iord;
  assign regdst   = ctrl_o.regdst;
  assign memtoreg = ctrl_o.memtoreg;
  assign alusrca  = ctrl_o.alusrca;
  assign alusrcb  = ctrl_o.alusrcb;
  assign pcsrc    = ctrl_o.pcsrc;
  assign illegal  = ctrl_o.illegal;
  assign state    = state_q;

endmodule

// File: tb/tb_cpu4_mc_ctrl.sv
// Self-checking bench for cpu4_mc_ctrl: directed test-plan cases, then random
// instructions compared cycle by cycle against a per-instruction trace model.
module tb_cpu4_mc_ctrl;
  import cpu4_mc_ctrl_pkg::*;

  localparam int W = 17;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, memwrite, irwrite, pcen, regwrite, iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   drv_q[$];

  cpu4_mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
    .regwrite(regwrite), .iord(iord), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal(illegal), .state(state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  wire [W-1:0] obs = {mem_req, memwrite, irwrite, pcen, regwrite, iord, regdst, memtoreg,
                      alusrca, alusrcb, pcsrc, alucontrol, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: each instruction is described as the list of cycles the
  // spec prescribes, with the inputs the bench will drive in that cycle.
  function automatic logic [W-1:0] vec(input bit req, wr, irw, pce, rw, io, rdst, m2r, srca,
                                       input bit [1:0] srcb, psrc, input bit [2:0] alu,
                                       input bit ill);
    return {req, wr, irw, pce, rw, io, rdst, m2r, srca, srcb, psrc, alu, ill};
  endfunction

  function automatic bit legal_op(input logic [5:0] o);
    logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    foreach (ops[i]) if (o == ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic [W-1:0] v, input bit rdy, input bit z);
    exp_q.push_back(v);
    drv_q.push_back({rdy, z});
  endtask

  // A non-memory cycle: mem_ready and zero are random noise the DUT must ignore.
  task automatic push_idle(input logic [W-1:0] v);
    push(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic push_mem(input logic [W-1:0] wait_v, input logic [W-1:0] done_v, input int waits);
    for (int i = 0; i < waits; i++) push(wait_v, 1'b0, 1'($urandom_range(0, 1)));
    push(done_v, 1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic push_fetch(input int waits);
    push_mem(vec(1,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b000,0),
             vec(1,0,1,1,0,0,0,0,0,2'b01,2'b00,3'b000,0), waits);
  endtask

  task automatic push_decode(input logic [5:0] o);
    push_idle(vec(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b000,!legal_op(o)));
  endtask

  task automatic push_memadr();
    push_idle(vec(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0));
  endtask

  task automatic model_instr(input logic [5:0] o, input logic [5:0] f,
                             input int wf, input int wm, input bit z);
    logic [W-1:0] v;
    push_fetch(wf);
    push_decode(o);
    if (o == 6'b100011) begin
      push_memadr();
      v = vec(1,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0);
      push_mem(v, v, wm);
      push_idle(vec(0,0,0,0,1,0,0,1,0,2'b00,2'b00,3'b000,0));
    end else if (o == 6'b101011) begin
      push_memadr();
      v = vec(1,1,0,0,0,1,0,0,0,2'b00,2'b00,3'b000,0);
      push_mem(v, v, wm);
    end else if (o == 6'b000000) begin
      if (f == 6'b100000 || f == 6'b100010) begin
        push_idle(vec(0,0,0,0,0,0,0,0,1,2'b00,2'b00, (f == 6'b100010) ? 3'b001 : 3'b000, 0));
        push_idle(vec(0,0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000,0));
      end else begin
        push_idle(vec(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b000,1));
      end
    end else if (o == 6'b000100) begin
      push(vec(0,0,0,z,0,0,0,0,1,2'b00,2'b01,3'b001,0), 1'($urandom_range(0, 1)), z);
    end else if (o == 6'b001000) begin
      push_idle(vec(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b000,0));
      push_idle(vec(0,0,0,0,1,0,0,0,0,2'b00,2'b00,3'b000,0));
    end else if (o == 6'b000010) begin
      push_idle(vec(0,0,0,1,0,0,0,0,0,2'b00,2'b10,3'b000,0));
    end
  endtask

  // Driver: apply one cycle's inputs after the edge, compare mid-cycle.
  task automatic run_queue(input string tag);
    logic [1:0]   d;
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      d = drv_q.pop_front();
      e = exp_q.pop_front();
      mem_ready = d[1];
      zero      = d[0];
      @(negedge clk);
      check(tag, obs, e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                           input int wf, input int wm, input bit z);
    op    = o;
    funct = f;
    check({tag, "_start_fetch"}, state, S_FETCH);
    model_instr(o, f, wf, wm, z);
    run_queue(tag);
  endtask

  initial begin
    logic [5:0] o, f;
    int r;
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs", obs, '0);
    check("reset_state", state, S_FETCH);
    reset = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a stalled lw read.
    op = 6'b100011;
    funct = '0;
    push_fetch(0);
    push_decode(6'b100011);
    push_memadr();
    run_queue("lw_pre_reset");
    mem_ready = 1'b0;
    check("memrd_req", {mem_req, iord}, 2'b11);
    #2 reset = 1'b1;
    #1;
    check("midreset_outputs", obs, '0);
    check("midreset_state", state, S_FETCH);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_req", mem_req, 1'b1);
    check("post_reset_state", state, S_FETCH);

    // Directed test-plan cases.
    run_instr("lw_w2",     6'b100011, 6'b000000, 2, 2, 0);
    run_instr("r_sub",     6'b000000, 6'b100010, 0, 0, 0);
    run_instr("r_add",     6'b000000, 6'b100000, 1, 0, 0);
    run_instr("r_bad",     6'b000000, 6'b100100, 0, 0, 0);
    run_instr("beq_z1",    6'b000100, 6'b000000, 0, 0, 1);
    run_instr("beq_z0",    6'b000100, 6'b000000, 0, 0, 0);
    run_instr("sw_w0",     6'b101011, 6'b000000, 0, 0, 0);
    run_instr("sw_w3",     6'b101011, 6'b000000, 0, 3, 0);
    run_instr("bad_op",    6'b111111, 6'b000000, 0, 0, 0);
    run_instr("jump",      6'b000010, 6'b000000, 0, 0, 0);
    run_instr("addi",      6'b001000, 6'b000000, 0, 0, 0);

    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        default: begin
          o = 6'($urandom_range(0, 63));
          while (legal_op(o)) o = 6'($urandom_range(0, 63));
        end
      endcase
      r = $urandom_range(0, 2);
      if (r == 0)      f = 6'b100000;
      else if (r == 1) f = 6'b100010;
      else begin
        f = 6'($urandom_range(0, 63));
        while (f == 6'b100000 || f == 6'b100010) f = 6'($urandom_range(0, 63));
      end
      run_instr("rand", o, f, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
